// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: state encoding, default memory
// size and the request-rejection check.
package lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_WR     = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4,
    ST_DONE   = 3'd5,
    ST_FAULT  = 3'd6
  } lsu_state_e;

  localparam int LSU_MEM_BYTES = 64;

  // A request is rejected when a word access is misaligned, when the first
  // byte lies outside memory, or when the access also touches addr+1 (word
  // accesses, and byte stores via their read-modify-write) and that byte
  // lies outside memory. Arithmetic is 17 bits so addr=16'hFFFF cannot wrap.
  function automatic logic lsu_is_fault(input logic [15:0]  addr,
                                        input logic         we,
                                        input logic         byte_op,
                                        input int unsigned  mem_bytes);
    logic [16:0] a_ext;
    logic [16:0] a_next;
    logic [16:0] lim;
    a_ext  = {1'b0, addr};
    a_next = a_ext + 17'd1;
    lim    = 17'(mem_bytes);
    lsu_is_fault = (!byte_op && addr[0])
                 || (a_ext >= lim)
                 || ((!byte_op || we) && (a_next >= lim));
  endfunction

endpackage

// File: rtl/load_store_unit.sv
// Load/store unit between a requester and a 16-bit little-endian data memory.
// Byte stores are done as a word read-modify-write so the neighbouring byte
// at addr+1 is written back unchanged.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   IDLE      | waiting for req; request fields latched on acceptance
//   RD        | load read issued; MemData captured into rdata at next edge
//   WR        | word store write issued
//   RMW_RD    | byte store: read the surrounding word into the merge reg
//   RMW_WR    | byte store: write {merge[15:8], wdata[7:0]}
//   DONE      | one-cycle completion pulse
//   FAULT     | one-cycle completion pulse with fault, no memory access
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = LSU_MEM_BYTES
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        req,
  input  logic        we,
  input  logic        byte_op,
  input  logic        sign_ext,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [15:0] rdata,
  output logic [15:0] MemAddress,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        CTRLBW,
  output logic        CTRLM,
  output logic [15:0] MemWriteData,
  input  logic [15:0] MemData
);

  lsu_state_e  state_q, state_d;
  logic        accept;

  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        byte_q;
  logic        sext_q;
  logic [15:0] rdata_q;
  logic [7:0]  merge_hi_q;

  // State register; reset aborts any in-flight access.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; req is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (lsu_is_fault(addr, we, byte_op, MEM_BYTES)) state_d = ST_FAULT;
          else if (!we)                                    state_d = ST_RD;
          else if (!byte_op)                               state_d = ST_WR;
          else                                             state_d = ST_RMW_RD;
        end
      end
      ST_RD:     state_d = ST_DONE;
      ST_WR:     state_d = ST_DONE;
      ST_RMW_RD: state_d = ST_RMW_WR;
      ST_RMW_WR: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      ST_FAULT:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Request latch, load result and merge byte.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      addr_q     <= 16'h0000;
      wdata_q    <= 16'h0000;
      byte_q     <= 1'b0;
      sext_q     <= 1'b0;
      rdata_q    <= 16'h0000;
      merge_hi_q <= 8'h00;
    end else begin
      if (accept) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        byte_q  <= byte_op;
        sext_q  <= sign_ext;
      end
      if (state_q == ST_RD)     rdata_q    <= MemData;
      if (state_q == ST_RMW_RD) merge_hi_q <= MemData[15:8];
    end
  end

  // Status and memory-side outputs decode registers only, so nothing on the
  // memory bus depends combinationally on the requester's inputs.
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE) || (state_q == ST_FAULT);
  assign fault        = (state_q == ST_FAULT);
  assign rdata        = rdata_q;
  assign MemAddress   = addr_q;
  assign MemRead      = (state_q == ST_RD) || (state_q == ST_RMW_RD);
  assign MemWrite     = (state_q == ST_WR) || (state_q == ST_RMW_WR);
  assign CTRLBW       = (state_q == ST_RD) && byte_q;
  assign CTRLM        = (state_q == ST_RD) && byte_q && sext_q;
  assign MemWriteData = (state_q == ST_WR)     ? wdata_q :
                        (state_q == ST_RMW_WR) ? {merge_hi_q, wdata_q[7:0]} :
                                                 16'h0000;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a little-endian byte memory model
// that updates on the falling clock edge.
module tb_load_store_unit;

  localparam int MB = 64;

  logic        Clk;
  logic        Rst_n;
  logic        req;
  logic        we;
  logic        byte_op;
  logic        sign_ext;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        busy;
  logic        done;
  logic        fault;
  logic [15:0] rdata;
  logic [15:0] MemAddress;
  logic        MemRead;
  logic        MemWrite;
  logic        CTRLBW;
  logic        CTRLM;
  logic [15:0] MemWriteData;
  logic [15:0] MemData;

  logic [7:0]  mem [0:MB-1];

  int          checks = 0;
  int          errors = 0;

  int          cyc;
  logic        seen_rd;
  logic        seen_wr;
  logic        seen_both;
  logic [15:0] wr_data_seen;
  logic        bw_first;
  logic        m_first;
  logic [15:0] addr_first;
  logic        fault_at_done;

  load_store_unit #(.MEM_BYTES(MB)) dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .req          (req),
    .we           (we),
    .byte_op      (byte_op),
    .sign_ext     (sign_ext),
    .addr         (addr),
    .wdata        (wdata),
    .busy         (busy),
    .done         (done),
    .fault        (fault),
    .rdata        (rdata),
    .MemAddress   (MemAddress),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .CTRLBW       (CTRLBW),
    .CTRLM        (CTRLM),
    .MemWriteData (MemWriteData),
    .MemData      (MemData)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Memory model: reads and writes take effect on the falling edge.
  initial begin
    int         a;
    logic [7:0] b;
    for (int i = 0; i < MB; i++) mem[i] = 8'h00;
    mem[2] = 8'h78;
    mem[3] = 8'hF6;
    mem[4] = 8'h82;
    mem[5] = 8'h80;
    MemData = 16'h0000;
    forever begin
      @(negedge Clk);
      a = int'(MemAddress);
      if (MemRead === 1'b1) begin
        if (CTRLBW === 1'b1) begin
          b = (a < MB) ? mem[a] : 8'h00;
          MemData = (CTRLM === 1'b1) ? {{8{b[7]}}, b} : {8'h00, b};
        end else if (a < MB - 1) begin
          MemData = {mem[a+1], mem[a]};
        end
      end
      if (MemWrite === 1'b1) begin
        if (a < MB) mem[a] = MemWriteData[7:0];
        if (CTRLBW !== 1'b1 && a < MB - 1) mem[a+1] = MemWriteData[15:8];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic sample();
    if (MemRead === 1'b1) seen_rd = 1'b1;
    if (MemWrite === 1'b1) begin
      seen_wr      = 1'b1;
      wr_data_seen = MemWriteData;
    end
    if (MemRead === 1'b1 && MemWrite === 1'b1) seen_both = 1'b1;
  endtask

  // Issue one request from IDLE and follow it to the done cycle (bounded).
  task automatic run(input logic w, input logic bo, input logic se,
                     input logic [15:0] a, input logic [15:0] wd);
    req = 1'b1; we = w; byte_op = bo; sign_ext = se; addr = a; wdata = wd;
    seen_rd = 1'b0; seen_wr = 1'b0; seen_both = 1'b0; wr_data_seen = 16'hxxxx;
    tick();
    req = 1'b0;
    cyc = 1;
    bw_first = CTRLBW; m_first = CTRLM; addr_first = MemAddress;
    sample();
    while (done !== 1'b1 && cyc < 8) begin
      tick();
      cyc++;
      sample();
    end
    fault_at_done = fault;
    chk1("done_reached", done, 1'b1);
    chk1("no_rd_wr_overlap", seen_both, 1'b0);
  endtask

  task automatic back_to_idle();
    tick();
    chk1("idle_after_done", busy, 1'b0);
    chk1("done_one_cycle", done, 1'b0);
  endtask

  initial begin
    Rst_n = 1'b0; req = 1'b0; we = 1'b0; byte_op = 1'b0; sign_ext = 1'b0;
    addr = 16'h0000; wdata = 16'h0000;
    #12;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_fault", fault, 1'b0);
    chk("rst_rdata", rdata, 16'h0000);
    chk1("rst_memread", MemRead, 1'b0);
    chk1("rst_memwrite", MemWrite, 1'b0);
    chk1("rst_ctrlbw", CTRLBW, 1'b0);
    chk1("rst_ctrlm", CTRLM, 1'b0);
    chk("rst_memaddr", MemAddress, 16'h0000);
    chk("rst_memwdata", MemWriteData, 16'h0000);
    #1 Rst_n = 1'b1;
    tick();
    chk1("idle_after_rst", busy, 1'b0);

    // word load at 2
    run(1'b0, 1'b0, 1'b0, 16'd2, 16'h0000);
    chk("wl2_cycles", 16'(cyc), 16'd2);
    chk("wl2_rdata", rdata, 16'hF678);
    chk1("wl2_fault", fault_at_done, 1'b0);
    chk1("wl2_ctrlbw", bw_first, 1'b0);
    chk1("wl2_ctrlm", m_first, 1'b0);
    chk("wl2_memaddr", addr_first, 16'd2);
    chk1("wl2_no_write", seen_wr, 1'b0);
    back_to_idle();

    // byte load at 3, sign-extended then zero-extended
    run(1'b0, 1'b1, 1'b1, 16'd3, 16'h0000);
    chk("bl3s_rdata", rdata, 16'hFFF6);
    chk("bl3s_cycles", 16'(cyc), 16'd2);
    chk1("bl3s_ctrlbw", bw_first, 1'b1);
    chk1("bl3s_ctrlm", m_first, 1'b1);
    back_to_idle();
    run(1'b0, 1'b1, 1'b0, 16'd3, 16'h0000);
    chk("bl3z_rdata", rdata, 16'h00F6);
    chk1("bl3z_ctrlm", m_first, 1'b0);
    back_to_idle();

    // reset pulsed during RMW_RD of a byte store to 4
    req = 1'b1; we = 1'b1; byte_op = 1'b1; sign_ext = 1'b0; addr = 16'd4; wdata = 16'h00A5;
    tick();
    req = 1'b0;
    chk1("rmw_rd_memread", MemRead, 1'b1);
    #1 Rst_n = 1'b0;
    #1;
    chk1("rst_mid_memread", MemRead, 1'b0);
    chk1("rst_mid_memwrite", MemWrite, 1'b0);
    chk1("rst_mid_busy", busy, 1'b0);
    tick();
    Rst_n = 1'b1;
    tick();
    tick();
    chk1("rst_abort_busy", busy, 1'b0);
    chk1("rst_abort_memwrite", MemWrite, 1'b0);
    chk("rst_abort_byte4", {8'h00, mem[4]}, 16'h0082);
    chk("rst_abort_byte5", {8'h00, mem[5]}, 16'h0080);
    chk("rst_abort_rdata", rdata, 16'h0000);

    // byte load at 2 gives a known rdata to watch across the store
    run(1'b0, 1'b1, 1'b0, 16'd2, 16'h0000);
    chk("bl2_rdata", rdata, 16'h0078);
    back_to_idle();

    // byte store 5A at 4; upper wdata bits must not reach memory
    run(1'b1, 1'b1, 1'b0, 16'd4, 16'hC35A);
    chk("bs4_cycles", 16'(cyc), 16'd3);
    chk1("bs4_fault", fault_at_done, 1'b0);
    chk1("bs4_did_read", seen_rd, 1'b1);
    chk("bs4_wdata", wr_data_seen, 16'h805A);
    chk("bs4_rdata_kept", rdata, 16'h0078);
    back_to_idle();
    chk("bs4_byte4", {8'h00, mem[4]}, 16'h005A);
    chk("bs4_byte5", {8'h00, mem[5]}, 16'h0080);

    run(1'b0, 1'b0, 1'b0, 16'd4, 16'h0000);
    chk("wl4_rdata", rdata, 16'h805A);
    back_to_idle();

    // word store then read back
    run(1'b1, 1'b0, 1'b0, 16'd6, 16'h1234);
    chk("ws6_cycles", 16'(cyc), 16'd2);
    chk("ws6_wdata", wr_data_seen, 16'h1234);
    chk1("ws6_no_read", seen_rd, 1'b0);
    back_to_idle();
    run(1'b0, 1'b0, 1'b0, 16'd6, 16'h0000);
    chk("wl6_rdata", rdata, 16'h1234);
    back_to_idle();

    // misaligned word load -> fault
    run(1'b0, 1'b0, 1'b0, 16'd5, 16'h0000);
    chk("wl5_cycles", 16'(cyc), 16'd1);
    chk1("wl5_fault", fault_at_done, 1'b1);
    chk1("wl5_no_read", seen_rd, 1'b0);
    chk("wl5_rdata_kept", rdata, 16'h1234);
    back_to_idle();
    chk1("wl5_fault_cleared", fault, 1'b0);

    // byte store at last byte -> fault (RMW would touch addr+1)
    run(1'b1, 1'b1, 1'b0, 16'd63, 16'h00EE);
    chk1("bs63_fault", fault_at_done, 1'b1);
    chk1("bs63_no_write", seen_wr, 1'b0);
    chk("bs63_byte63", {8'h00, mem[63]}, 16'h0000);
    back_to_idle();

    // byte load at last byte is legal; one past the end is not
    run(1'b0, 1'b1, 1'b0, 16'd63, 16'h0000);
    chk1("bl63_fault", fault_at_done, 1'b0);
    chk("bl63_rdata", rdata, 16'h0000);
    back_to_idle();
    run(1'b0, 1'b1, 1'b0, 16'd64, 16'h0000);
    chk1("bl64_fault", fault_at_done, 1'b1);
    chk1("bl64_no_read", seen_rd, 1'b0);
    back_to_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
